seg7_scan_driver: RTL
=====================

Name: seg7_scan_driver

Overview:
- Parametrised time-multiplexed driver for an N-digit common-anode 7-segment display bank.
- Captures a packed hex word on a load strobe and scans one digit per refresh slot.
- Drives the digit anodes, segments and decimal point.
- Adds leading-zero blanking, per-digit decimal points and a global enable; sits between datapath outputs and board display pins.

Parameters:
- N_DIGITS, 8, number of digits scanned; legal range 1..16.
- REFRESH_DIV, 100000, clk cycles per digit slot; must be >= 2.
- ACTIVE_LOW, 1, 1 = anodes, segments and dp are active-low at the pins; 0 = active-high.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- value_in  in  4*N_DIGITS  packed nibbles; nibble i = digit i, digit 0 is rightmost
- dp_in  in  N_DIGITS  decimal point request per digit, captured with value_in
- load  in  1  capture strobe for value_in and dp_in
- blank_lz  in  1  leading-zero blanking mode
- enable  in  1  0 forces the display dark
- anodes  out  N_DIGITS  digit select, one-hot when lit
- segments  out  7  bits {a,b,c,d,e,f,g}; bit6 = a
- dp_out  out  1  decimal point of the selected digit

Behaviour:
- Reset, synchronous, active-high, highest priority over load and enable:
  - shadow value and shadow dp = 0; refresh counter = 0; digit index = 0.
  - All outputs inactive: anodes all off, segments all off, dp off. At the pins this is all-ones when ACTIVE_LOW=1.
- Capture: load=1 at edge t → shadow registers updated at t+1. Visible on the outputs at t+2 if that digit is selected. There is no handshake; load may be held high.
- Refresh counter, width $clog2(REFRESH_DIV):
  - Counts 0..REFRESH_DIV-1 while enable=1.
  - At terminal count it wraps to 0 and the digit index advances. The index wraps from N_DIGITS-1 to 0.
  - Index width is max(1,$clog2(N_DIGITS)).
  - N_DIGITS=1: index stays 0.
- enable=0: counter and index hold. From the next cycle, anodes, segments and dp are inactive. When enable returns to 1, scanning resumes from the held index and count.
- Outputs are registered from (shadow, index). An index change at edge t appears on the pins at t+1. Exactly one anode is active whenever enable=1 and the block is out of reset.
- Glyph table, active-high, before polarity: 0:7E 1:30 2:6D 3:79 4:33 5:5B 6:5F 7:70 8:7F 9:7B A:77 b:1F C:4E d:3D E:4F F:47. ACTIVE_LOW=1 inverts segments, dp and anodes.
- Leading-zero blanking, when blank_lz=1:
  - Digit i (i>0) has its segments off if nibbles N_DIGITS-1..i are all zero. Digit 0 is never blanked.
  - The anode still steps through every digit.
  - dp_out follows shadow dp even on a blanked digit.
  - blank_lz is sampled live, not captured.
- Simultaneous load and index advance in the same cycle: the new index displays the old shadow for one cycle, then the new shadow. No glitch beyond this.

Decomposition:
- Package seg7_pkg holds:
  - typedef seg7_t (logic [6:0]).
  - The 16 glyph localparams SEG_0..SEG_F and SEG_OFF.
  - Function hex_to_seg7(nibble) returning seg7_t.
- One combinational sub-module, hex7seg_decode: 4-bit in, seg7_t out, uses the package function. Instantiated once, fed by the mux of the selected nibble.
- Counter, index, shadow registers, blanking and polarity logic stay in seg7_scan_driver.

Test Plan:
- Reset check (N_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1): reset high for 3 cycles → anodes=4'hF, segments=7'h7F, dp_out=1 throughout. Release → anodes=4'b1110 one cycle later.
- Scan wrap: load value_in=16'h12AF, enable=1 → anodes sequence 1110,1101,1011,0111,1110 at 4-cycle spacing. Segments show ~7'h47, ~7'h77, ~7'h6D, ~7'h30.
- Leading-zero blanking: value_in=16'h0030, blank_lz=1 → digits 3 and 2 give segments=7'h7F, digit 1 gives ~7'h79, digit 0 gives ~7'h7E. With blank_lz=0, digits 3 and 2 give ~7'h7E.
- Decimal point and enable: dp_in=4'b0100 → dp_out=0 only while anodes=1011. Drop enable for 10 cycles → all outputs inactive and the index is frozen. Re-enable → scanning resumes at the frozen digit.
- Load versus reset collision: load=1 and reset=1 on the same edge → shadow=0 and all outputs inactive. Load alone at edge t → the new glyph appears at t+2 on the selected digit.

Source files
------------

// File: rtl/seg7_pkg.sv
// Glyph encodings and the hex-to-segment lookup shared by the 7-segment display logic.
// Segment bits are {a,b,c,d,e,f,g} with a in bit 6, active-high before any pin polarity.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_0   = 7'h7E;
    localparam seg7_t SEG_1   = 7'h30;
    localparam seg7_t SEG_2   = 7'h6D;
    localparam seg7_t SEG_3   = 7'h79;
    localparam seg7_t SEG_4   = 7'h33;
    localparam seg7_t SEG_5   = 7'h5B;
    localparam seg7_t SEG_6   = 7'h5F;
    localparam seg7_t SEG_7   = 7'h70;
    localparam seg7_t SEG_8   = 7'h7F;
    localparam seg7_t SEG_9   = 7'h7B;
    localparam seg7_t SEG_A   = 7'h77;
    localparam seg7_t SEG_B   = 7'h1F;
    localparam seg7_t SEG_C   = 7'h4E;
    localparam seg7_t SEG_D   = 7'h3D;
    localparam seg7_t SEG_E   = 7'h4F;
    localparam seg7_t SEG_F   = 7'h47;
    localparam seg7_t SEG_OFF = 7'h00;

    function automatic seg7_t hex_to_seg7(input logic [3:0] nibble);
        seg7_t seg;
        case (nibble)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational hex nibble to active-high 7-segment glyph, zero latency.
// No state and no flow control; output follows the input within the cycle.
module hex7seg_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_seg7(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver: load -> pins in two cycles, index change -> pins in one.
// No backpressure: load is a bare strobe that may be held; enable=0 freezes the scan and darkens the pins.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS    = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*N_DIGITS-1:0]   value_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic                    enable,
    output logic [N_DIGITS-1:0]     anodes,
    output logic [6:0]              segments,
    output logic                    dp_out
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
    localparam logic INV = (ACTIVE_LOW != 0);

    logic [4*N_DIGITS-1:0] in_val;
    logic [N_DIGITS-1:0]   in_dp;
    logic                  in_load;
    logic [4*N_DIGITS-1:0] shadow_val;
    logic [N_DIGITS-1:0]   shadow_dp;
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;

    logic [N_DIGITS-1:0]   lead_zero;
    logic [N_DIGITS-1:0]   onehot;
    logic [3:0]            sel_nib;
    logic                  sel_dp;
    logic                  sel_lz;
    logic                  blank;
    logic [6:0]            glyph;

    // lead_zero[i]: every nibble from the top down to digit i is zero.
    always_comb begin
        logic run;
        run       = 1'b1;
        lead_zero = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            run          = run && (shadow_val[4*i +: 4] == 4'h0);
            lead_zero[i] = run;
        end
    end

    always_comb begin
        onehot  = '0;
        sel_nib = 4'h0;
        sel_dp  = 1'b0;
        sel_lz  = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                onehot[i] = 1'b1;
                sel_nib   = shadow_val[4*i +: 4];
                sel_dp    = shadow_dp[i];
                sel_lz    = lead_zero[i];
            end
        end
    end

    assign blank = blank_lz && (idx != '0) && sel_lz;

    hex7seg_decode u_decode (
        .nibble (sel_nib),
        .seg    (glyph)
    );

    // Input stage delays capture by one cycle so a load coinciding with an index step
    // shows the old shadow on the new digit for exactly one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_load    <= 1'b0;
            in_val     <= '0;
            in_dp      <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
        end else begin
            in_load <= load;
            if (load) begin
                in_val <= value_in;
                in_dp  <= dp_in;
            end
            if (in_load) begin
                shadow_val <= in_val;
                shadow_dp  <= in_dp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (enable) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            anodes   <= {N_DIGITS{INV}};
            segments <= {7{INV}};
            dp_out   <= INV;
        end else begin
            anodes   <= onehot ^ {N_DIGITS{INV}};
            segments <= (blank ? SEG_OFF : glyph) ^ {7{INV}};
            dp_out   <= sel_dp ^ INV;
        end
    end

endmodule
